// File: rtl/conv_pkg.sv
// Shared helpers for the convolution datapath: accumulator extension width
// and output saturation.
package conv_pkg;

  // Room for sum + bias + rounding constant without wrap.
  function automatic int acc_ext_width(input int in_w, input int bias_w);
    return ((in_w > bias_w) ? in_w : bias_w) + 2;
  endfunction

  function automatic longint sat_clamp(input longint value, input int width,
                                       input logic is_signed);
    longint hi;
    longint lo;
    if (is_signed) begin
      hi = (longint'(1) <<< (width - 1)) - 1;
      lo = -(longint'(1) <<< (width - 1));
    end else begin
      hi = (longint'(1) <<< width) - 1;
      lo = 0;
    end
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// Single valid/ready register slice carrying data plus tlast; an empty slot
// always accepts, so bubbles are filled even while downstream is stalled.
module pipe_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_last <= in_last;
      end
    end
  end

endmodule

// File: rtl/bias_activation.sv
// Bias add + rounding shift + optional ReLU + saturation, two register stages
// with a combinational ready chain for full-rate AXI-Stream operation.
module bias_activation
  import conv_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int BIAS_WIDTH = 16,
  parameter int OUT_WIDTH  = 8,
  parameter int CHANNELS   = 1,
  parameter int FRAC_SHIFT = 8,
  parameter int RELU       = 1
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic [BIAS_WIDTH*CHANNELS-1:0]  bias_i,
  input  logic                            slave_tvalid_i,
  output logic                            slave_tready_o,
  input  logic [IN_WIDTH*CHANNELS-1:0]    slave_tdata_i,
  input  logic                            slave_tlast_i,
  output logic                            master_tvalid_o,
  input  logic                            master_tready_i,
  output logic [OUT_WIDTH*CHANNELS-1:0]   master_tdata_o,
  output logic                            master_tlast_o
);

  localparam int W      = acc_ext_width(IN_WIDTH, BIAS_WIDTH);
  localparam int RND_SH = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
  localparam logic [W-1:0] RND = (FRAC_SHIFT > 0) ? (W'(1) << RND_SH) : '0;

  logic [W*CHANNELS-1:0]         s1_d, s1_q;
  logic [OUT_WIDTH*CHANNELS-1:0] s2_d;
  logic                          s1_valid, s1_last, s2_ready;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic signed [W-1:0] q;
    // Adding half an LSB before the floor shift gives round-half-up.
    assign s1_d[ch*W +: W] = W'($signed(slave_tdata_i[ch*IN_WIDTH +: IN_WIDTH]))
                           + W'($signed(bias_i[ch*BIAS_WIDTH +: BIAS_WIDTH]))
                           + RND;
    assign q = $signed(s1_q[ch*W +: W]) >>> FRAC_SHIFT;
    assign s2_d[ch*OUT_WIDTH +: OUT_WIDTH] =
      OUT_WIDTH'(sat_clamp(longint'(q), OUT_WIDTH, RELU == 0));
  end

  pipe_stage #(.DATA_WIDTH(W*CHANNELS)) u_s1 (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .in_valid (slave_tvalid_i),
    .in_ready (slave_tready_o),
    .in_data  (s1_d),
    .in_last  (slave_tlast_i),
    .out_valid(s1_valid),
    .out_ready(s2_ready),
    .out_data (s1_q),
    .out_last (s1_last)
  );

  pipe_stage #(.DATA_WIDTH(OUT_WIDTH*CHANNELS)) u_s2 (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .in_valid (s1_valid),
    .in_ready (s2_ready),
    .in_data  (s2_d),
    .in_last  (s1_last),
    .out_valid(master_tvalid_o),
    .out_ready(master_tready_i),
    .out_data (master_tdata_o),
    .out_last (master_tlast_o)
  );

endmodule

// File: tb/tb_bias_activation.sv
// Directed and streaming checks for bias_activation in ReLU, signed and
// four-channel configurations.
module tb_bias_activation;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bias = '0, d = '0;
  logic        v = 1'b0, l = 1'b0, mready = 1'b1;
  logic        a_ready, a_valid, a_last, s_ready, s_valid, s_last;
  logic [7:0]  a_data, s_data;
  logic [63:0] m_bias = '0, m_d = '0;
  logic        m_v = 1'b0, m_l = 1'b0, m_mready = 1'b1;
  logic        m_ready, m_valid, m_last;
  logic [31:0] m_data;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  bias_activation dut_a (
    .clock_i(clk), .reset_i(rst), .bias_i(bias),
    .slave_tvalid_i(v), .slave_tready_o(a_ready), .slave_tdata_i(d), .slave_tlast_i(l),
    .master_tvalid_o(a_valid), .master_tready_i(mready), .master_tdata_o(a_data),
    .master_tlast_o(a_last));

  bias_activation #(.RELU(0)) dut_s (
    .clock_i(clk), .reset_i(rst), .bias_i(bias),
    .slave_tvalid_i(v), .slave_tready_o(s_ready), .slave_tdata_i(d), .slave_tlast_i(l),
    .master_tvalid_o(s_valid), .master_tready_i(mready), .master_tdata_o(s_data),
    .master_tlast_o(s_last));

  bias_activation #(.CHANNELS(4)) dut_m (
    .clock_i(clk), .reset_i(rst), .bias_i(m_bias),
    .slave_tvalid_i(m_v), .slave_tready_o(m_ready), .slave_tdata_i(m_d), .slave_tlast_i(m_l),
    .master_tvalid_o(m_valid), .master_tready_i(m_mready), .master_tdata_o(m_data),
    .master_tlast_o(m_last));

  // Golden model: sext sum + half LSB, floor shift by 8, clamp to 8 bits.
  function automatic logic [7:0] model(input logic [15:0] dd, input logic [15:0] bb,
                                       input bit relu);
    int s;
    s = int'($signed(dd)) + int'($signed(bb)) + 128;
    s = s >>> 8;
    if (relu) begin
      if (s < 0) s = 0;
      if (s > 255) s = 255;
    end else begin
      if (s < -128) s = -128;
      if (s > 127) s = 127;
    end
    return s[7:0];
  endfunction

  // Single element through the empty ReLU/signed pair with no stall.
  task automatic run_a(input logic [15:0] dd, input logic [15:0] bb, input logic ll,
                       output logic [7:0] qa, output logic [7:0] qs, output logic la,
                       output bit to);
    @(negedge clk);
    bias = bb; d = dd; l = ll; v = 1'b1; mready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v = 1'b0; l = 1'b0;
    to = 1'b1; qa = '0; qs = '0; la = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (a_valid) begin
        qa = a_data; qs = s_data; la = a_last; to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_m(input logic [63:0] dd, input logic [63:0] bb, input logic ll,
                       output logic [31:0] q, output logic la, output bit to);
    @(negedge clk);
    m_bias = bb; m_d = dd; m_l = ll; m_v = 1'b1; m_mready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_v = 1'b0; m_l = 1'b0;
    to = 1'b1; q = '0; la = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (m_valid) begin
        q = m_data; la = m_last; to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (a_valid !== 1'b0 || a_data !== 8'h00 || a_last !== 1'b0) begin
      n_err++; $display("FAIL reset_out_a: got v=%b d=%h l=%b expected 0/00/0", a_valid, a_data, a_last);
    end
    n_vec++;
    if (m_valid !== 1'b0 || m_data !== 32'h0) begin
      n_err++; $display("FAIL reset_out_m: got v=%b d=%h expected 0/0", m_valid, m_data);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (a_ready !== 1'b1 || m_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got a=%b m=%b expected 1/1", a_ready, m_ready);
    end
  endtask

  task automatic test_bias_round;
    logic [15:0] td[5] = '{16'd256, 16'd256, 16'd383, 16'd384, 16'd256};
    logic [15:0] tb[5] = '{16'd128, 16'd0,   16'd0,   16'd0,   16'hFF80};
    logic [7:0]  te[5] = '{8'd2,    8'd1,    8'd1,    8'd2,    8'd1};
    logic [7:0] qa, qs; logic la; bit to;
    for (int i = 0; i < 5; i++) begin
      run_a(td[i], tb[i], i == 2, qa, qs, la, to);
      n_vec++;
      if (to || qa !== te[i] || la !== (i == 2)) begin
        n_err++; $display("FAIL bias_round[%0d]: got %h last=%b to=%b expected %h last=%b",
                          i, qa, la, to, te[i], i == 2);
      end
    end
  endtask

  task automatic test_relu_sat;
    logic [15:0] td[6] = '{-16'sd1000, 16'h7FFF, 16'h7F80, 16'h7FFF, 16'h7FFF, 16'h8000};
    logic [15:0] tb[6] = '{16'd0,      16'd0,    16'd0,    16'd32512, 16'd32641, 16'h8000};
    logic [7:0]  te[6] = '{8'd0,       8'd128,   8'd128,   8'd255,   8'd255,    8'd0};
    logic [7:0] qa, qs; logic la; bit to;
    for (int i = 0; i < 6; i++) begin
      run_a(td[i], tb[i], 1'b0, qa, qs, la, to);
      n_vec++;
      if (to || qa !== te[i]) begin
        n_err++; $display("FAIL relu_sat[%0d]: got %h to=%b expected %h", i, qa, to, te[i]);
      end
    end
  endtask

  task automatic test_signed;
    logic [15:0] td[6] = '{16'h8000, -16'sd384, 16'd32512, 16'h7FFF, 16'h8000, -16'sd1000};
    logic [15:0] tb[6] = '{16'd0,    16'd0,     16'd0,     16'd0,    16'h8000, 16'd0};
    logic [7:0]  te[6] = '{8'h80,    8'hFF,     8'h7F,     8'h7F,    8'h80,    8'hFC};
    logic [7:0] qa, qs; logic la; bit to;
    for (int i = 0; i < 6; i++) begin
      run_a(td[i], tb[i], 1'b0, qa, qs, la, to);
      n_vec++;
      if (to || qs !== te[i]) begin
        n_err++; $display("FAIL signed[%0d]: got %h to=%b expected %h", i, qs, to, te[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] vec[100];
    int in_c = 0, out_c = 0;
    bit stall = 1'b0;
    logic [7:0] pd = '0, ex;
    logic pl = 1'b0;
    for (int i = 0; i < 100; i++) vec[i] = 16'($urandom);
    @(negedge clk);
    bias = 16'd300;
    for (int cyc = 0; cyc < 3000 && out_c < 100; cyc++) begin
      @(negedge clk);
      if (stall) begin
        n_vec++;
        if (a_valid !== 1'b1 || a_data !== pd || a_last !== pl) begin
          n_err++; $display("FAIL stall_hold: got v=%b d=%h l=%b expected 1/%h/%b",
                            a_valid, a_data, a_last, pd, pl);
        end
      end
      v = (in_c < 100);
      d = (in_c < 100) ? vec[in_c] : 16'h0;
      l = (in_c % 10 == 9);
      mready = ($urandom_range(0, 9) < 3);
      #1;
      if (a_valid && mready) begin
        ex = model(vec[out_c], 16'd300, 1'b1);
        n_vec++;
        if (a_data !== ex || a_last !== (out_c % 10 == 9)) begin
          n_err++; $display("FAIL bp_data[%0d]: got %h last=%b expected %h last=%b",
                            out_c, a_data, a_last, ex, out_c % 10 == 9);
        end
        out_c++;
      end
      stall = a_valid && !mready;
      pd = a_data; pl = a_last;
      if (v && a_ready) in_c++;
    end
    v = 1'b0; l = 1'b0; mready = 1'b1;
    n_vec++;
    if (out_c != 100) begin
      n_err++; $display("FAIL bp_count: got %0d outputs expected 100", out_c);
    end
  endtask

  task automatic test_back_to_back;
    int in_c = 0, out_c = 0, first_acc = -1, first_out = -1, last_out = 0;
    @(negedge clk);
    bias = 16'd0;
    for (int cyc = 0; cyc < 200 && out_c < 50; cyc++) begin
      @(negedge clk);
      v = (in_c < 50);
      d = 16'(in_c * 256);
      mready = 1'b1;
      #1;
      if (v) begin
        n_vec++;
        if (a_ready !== 1'b1) begin
          n_err++; $display("FAIL b2b_ready[%0d]: got %b expected 1", in_c, a_ready);
        end
      end
      if (a_valid) begin
        if (first_out < 0) first_out = cyc;
        else if (cyc != last_out + 1) begin
          n_err++; $display("FAIL b2b_gap: got output at cycle %0d expected %0d", cyc, last_out + 1);
        end
        last_out = cyc;
        n_vec++;
        if (a_data !== 8'(out_c)) begin
          n_err++; $display("FAIL b2b_data[%0d]: got %h expected %h", out_c, a_data, 8'(out_c));
        end
        out_c++;
      end
      if (v && a_ready) begin
        if (first_acc < 0) first_acc = cyc;
        in_c++;
      end
    end
    v = 1'b0;
    n_vec++;
    if (out_c != 50 || first_out - first_acc != 2) begin
      n_err++; $display("FAIL b2b_latency: got count=%0d latency=%0d expected 50/2",
                        out_c, first_out - first_acc);
    end
  endtask

  task automatic test_reset_midstream;
    logic [7:0] qa, qs; logic la; bit to;
    int extra = 0;
    @(negedge clk);
    mready = 1'b0; bias = 16'd0; v = 1'b1; d = 16'd2560;
    @(posedge clk);
    @(negedge clk);
    d = 16'd5120;
    @(posedge clk);
    @(negedge clk);
    v = 1'b0;
    n_vec++;
    if (a_ready !== 1'b0 || a_valid !== 1'b1) begin
      n_err++; $display("FAIL full_stall: got ready=%b valid=%b expected 0/1", a_ready, a_valid);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (a_valid !== 1'b0 || a_data !== 8'h00) begin
      n_err++; $display("FAIL mid_reset: got v=%b d=%h expected 0/00", a_valid, a_data);
    end
    @(negedge clk);
    n_vec++;
    if (a_valid !== 1'b0 || a_ready !== 1'b1) begin
      n_err++; $display("FAIL post_reset: got v=%b rdy=%b expected 0/1", a_valid, a_ready);
    end
    run_a(16'd768, 16'd0, 1'b1, qa, qs, la, to);
    n_vec++;
    if (to || qa !== 8'd3 || la !== 1'b1) begin
      n_err++; $display("FAIL after_reset: got %h last=%b to=%b expected 03/1", qa, la, to);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (a_valid) extra++;
    end
    n_vec++;
    if (extra != 0) begin
      n_err++; $display("FAIL after_reset_extra: got %0d extra outputs expected 0", extra);
    end
  endtask

  task automatic test_multichannel;
    logic [31:0] q; logic la; bit to;
    run_m({4{16'd1280}}, {16'd1024, 16'hFE00, 16'd256, 16'd0}, 1'b0, q, la, to);
    n_vec++;
    if (to || q !== 32'h09030605) begin
      n_err++; $display("FAIL multi_0: got %h to=%b expected 09030605", q, to);
    end
    run_m({4{16'hFF00}}, {16'd1024, 16'hFE00, 16'd256, 16'd0}, 1'b1, q, la, to);
    n_vec++;
    if (to || q !== 32'h03000000 || la !== 1'b1) begin
      n_err++; $display("FAIL multi_1: got %h last=%b to=%b expected 03000000/1", q, la, to);
    end
  endtask

  initial begin
    test_reset;
    test_bias_round;
    test_relu_sat;
    test_signed;
    test_backpressure;
    test_back_to_back;
    test_reset_midstream;
    test_multichannel;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
